gcm_block_sequencer: RTL and testbench
======================================

Name: gcm_block_sequencer

Overview:
- Front-end scheduler for the AES-GCM pipeline.
- Accepts one instance descriptor (IV, AAD bit-length, PT bit-length), then streams that instance's AAD and text blocks into the pipeline.
- Tags every block with a phase code and a counter block (IV||ctr32). Appends the GHASH length block at the end.
- Provides valid/ready flow control so the AES stages can stall without losing data.

Parameters:
- CTR_START, 2, initial 32-bit counter value for the first text block (J0+1 for a 96-bit IV).
- LEN_W, 64, width of each length field in bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_desc_valid  in  1  descriptor offered
- o_desc_ready  out  1  descriptor accepted when both valid and ready are high
- i_iv  in  96  IV for the instance
- i_aad_len  in  LEN_W  AAD length in bits
- i_pt_len  in  LEN_W  PT length in bits
- i_blk_valid  in  1  source data block valid
- o_blk_ready  out  1  source data block consumed
- i_blk  in  128  AAD or text block
- o_valid  out  1  output entry valid
- i_ready  in  1  pipeline accepts entry
- o_blk  out  128  block forwarded to the pipeline
- o_ctr_block  out  128  {iv, ctr32}; zero for AAD and length entries
- o_phase  out  3  phase code
- o_new_instance  out  1  first entry of an instance
- o_byte_cnt  out  5  valid bytes in o_blk, 1..16
- o_done  out  1  one-cycle pulse when the length entry is accepted
- o_err  out  1  only with GCM_CTR_WRAP_ERR_EN (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0 except o_desc_ready=1; internal counters cleared. A reset mid-instance abandons it; no o_done is produced.
- Block counts:
  - na = ceil(aad_len/128); nt = ceil(pt_len/128).
  - Computed once, at descriptor accept, into registers.
- FSM:
  - IDLE: o_desc_ready=1. On accept, latch the IV, lengths and counts; ctr32 = CTR_START. Go to AAD if na>0, else TEXT if nt>0, else LEN.
  - AAD: consume na blocks. After the last one, go to TEXT if nt>0, else LEN.
  - TEXT: consume nt blocks. ctr32 increments by 1 per block, modulo 2^32 (inc32; upper 96 bits never change). After the last one, go to LEN.
  - LEN: emit one entry with o_blk = {aad_len, pt_len}. On accept, pulse o_done and return to IDLE.
- Output register (single entry):
  - o_blk_ready = (state is AAD or TEXT) && (!o_valid || i_ready).
  - A consumed source block loads the output register on the next clock edge, so latency is 1 cycle.
  - o_valid and all tags hold steady while i_ready=0.
  - Simultaneous accept-out and load-in in the same cycle is supported, giving one block per cycle of throughput.
  - In LEN, the entry loads only when the output register is empty or being drained.
- Phase codes:
  - 010 AAD block.
  - 000 first text block (not last).
  - 001 middle text block.
  - 011 last text block.
  - 111 text block that is both first and last.
  - 101 length block.
  - 100 is never emitted.
- o_byte_cnt:
  - 16 for every entry, except the last AAD and last text block.
  - For those, it equals ((len-1)>>3 mod 16)+1.
  - Length bits not a multiple of 8 are rounded up to the next byte.
- o_new_instance=1 only on the first entry after a descriptor. For the 0/0 case, that is the length entry.
- No new descriptor is accepted until o_done has pulsed.

Optional Feature:
- Macro GCM_CTR_WRAP_ERR_EN.
- Defined:
  - A descriptor with nt > 2^32-2 is accepted, but o_err pulses for 1 cycle and the FSM stays in IDLE.
  - o_err resets to 0.
- Undefined:
  - o_err is tied to 0.
  - Such descriptors run normally, and ctr32 wraps from 0xFFFFFFFF to 0.

Test Plan:
- aad_len=256, pt_len=384, i_ready=1 -> 6 entries; phases 010,010,000,001,011,101; ctr32 2,3,4 on the text entries; o_done on the 6th.
- aad_len=0, pt_len=100 -> phase 111 with o_byte_cnt=13 and o_new_instance=1, then 101 with o_blk={64'd0,64'd100}.
- aad_len=0, pt_len=0 -> a single length entry with o_new_instance=1 and phase 101; o_desc_ready drops for exactly the descriptor-accept-to-done interval.
- i_ready held low 5 cycles mid-text -> o_valid, o_blk and o_phase are stable and o_blk_ready=0; no block is lost or duplicated after release.
- Reset asserted mid-TEXT -> all outputs go to 0 immediately and o_desc_ready=1; the next descriptor restarts at ctr32=2.
- With CTR_START=32'hFFFFFFFF and pt_len=256, macro undefined -> ctr32 FFFFFFFF then 00000000. With the macro defined and pt_len=(2^32-1)*128 -> o_err pulses and the FSM remains in IDLE.

Source files
------------

// File: rtl/gcm_block_sequencer.sv
// AES-GCM front-end scheduler: takes one descriptor, streams AAD/text blocks with phase and counter tags, then appends the length block.
// Optional macro GCM_CTR_WRAP_ERR_EN: rejects descriptors whose text block count would exhaust the 32-bit counter.
module gcm_block_sequencer #(
    parameter logic [31:0] CTR_START = 32'd2,
    parameter int          LEN_W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_desc_valid,
    output logic             o_desc_ready,
    input  logic [95:0]      i_iv,
    input  logic [LEN_W-1:0] i_aad_len,
    input  logic [LEN_W-1:0] i_pt_len,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [127:0]     i_blk,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_blk,
    output logic [127:0]     o_ctr_block,
    output logic [2:0]       o_phase,
    output logic             o_new_instance,
    output logic [4:0]       o_byte_cnt,
    output logic             o_done,
    output logic             o_err
);
    localparam int CW = LEN_W - 6;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
    typedef enum logic [2:0] {S_IDLE, S_AAD, S_TEXT, S_LEN, S_LEN_WAIT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [95:0]      r_iv;
    logic [LEN_W-1:0] r_aad_len;
    logic [LEN_W-1:0] r_pt_len;
    logic [CW-1:0]    r_aad_left;
    logic [CW-1:0]    r_txt_left;
    logic [31:0]      r_ctr;
    logic             r_txt_first;
    logic             r_new_pending;

    logic             r_valid;
    logic [127:0]     r_blk;
    logic [127:0]     r_ctr_blk;
    logic [2:0]       r_phase;
    logic             r_new;
    logic [4:0]       r_bytes;
    logic             r_err;

    logic [CW-1:0]    w_na;
    logic [CW-1:0]    w_nt;
    logic             w_desc_acc;
    logic             w_wrap_err;
    logic             w_out_free;
    logic             w_blk_ready;
    logic             w_load_blk;
    logic             w_load_len;
    logic             w_len_acc;
    logic [3:0]       w_aad_b;
    logic [3:0]       w_pt_b;
    logic [127:0]     w_ld_blk;
    logic [127:0]     w_ld_ctr;
    logic [2:0]       w_ld_phase;
    logic [4:0]       w_ld_bytes;

    assign w_na = CW'(i_aad_len >> 7) + CW'(|i_aad_len[6:0]);
    assign w_nt = CW'(i_pt_len >> 7) + CW'(|i_pt_len[6:0]);

`ifdef GCM_CTR_WRAP_ERR_EN
    assign w_wrap_err = (w_nt > CW'(64'hFFFF_FFFE));
    assign o_err      = r_err;
`else
    assign w_wrap_err = 1'b0;
    assign o_err      = 1'b0;
`endif

    assign w_desc_acc  = i_desc_valid && (r_state == S_IDLE);
    assign w_out_free  = !r_valid || i_ready;
    assign w_blk_ready = ((r_state == S_AAD) || (r_state == S_TEXT)) && w_out_free;
    assign w_load_blk  = w_blk_ready && i_blk_valid;
    assign w_load_len  = (r_state == S_LEN) && w_out_free;
    assign w_len_acc   = (r_state == S_LEN_WAIT) && i_ready;

    // Byte count of a final block = ceil(len/8) mod 16, with 0 meaning a full 16 bytes.
    assign w_aad_b = r_aad_len[6:3] + 4'(|r_aad_len[2:0]);
    assign w_pt_b  = r_pt_len[6:3] + 4'(|r_pt_len[2:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_desc_acc && !w_wrap_err) begin
                    if (w_na != '0)      w_next = S_AAD;
                    else if (w_nt != '0) w_next = S_TEXT;
                    else                 w_next = S_LEN;
                end
            end
            S_AAD: begin
                if (w_load_blk && (r_aad_left == CW'(1)))
                    w_next = (r_txt_left != '0) ? S_TEXT : S_LEN;
            end
            S_TEXT: begin
                if (w_load_blk && (r_txt_left == CW'(1))) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_load_len) w_next = S_LEN_WAIT;
            end
            S_LEN_WAIT: begin
                if (w_len_acc) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ld_blk   = 128'(i_blk);
        w_ld_ctr   = '0;
        w_ld_phase = 3'b010;
        w_ld_bytes = 5'd16;
        case (r_state)
            S_AAD: begin
                if ((r_aad_left == CW'(1)) && (w_aad_b != 4'd0)) w_ld_bytes = {1'b0, w_aad_b};
            end
            S_TEXT: begin
                w_ld_ctr = {r_iv, r_ctr};
                if (r_txt_left == CW'(1)) begin
                    w_ld_phase = r_txt_first ? 3'b111 : 3'b011;
                    if (w_pt_b != 4'd0) w_ld_bytes = {1'b0, w_pt_b};
                end else begin
                    w_ld_phase = r_txt_first ? 3'b000 : 3'b001;
                end
            end
            S_LEN: begin
                w_ld_blk   = 128'({r_aad_len, r_pt_len});
                w_ld_phase = 3'b101;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iv          <= '0;
            r_aad_len     <= '0;
            r_pt_len      <= '0;
            r_aad_left    <= '0;
            r_txt_left    <= '0;
            r_ctr         <= '0;
            r_txt_first   <= 1'b0;
            r_new_pending <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= w_desc_acc && w_wrap_err;
            if (w_desc_acc) begin
                r_iv          <= i_iv;
                r_aad_len     <= i_aad_len;
                r_pt_len      <= i_pt_len;
                r_aad_left    <= w_na;
                r_txt_left    <= w_nt;
                r_ctr         <= CTR_START;
                r_txt_first   <= 1'b1;
                r_new_pending <= 1'b1;
            end else begin
                if (w_load_blk || w_load_len) r_new_pending <= 1'b0;
                if (w_load_blk && (r_state == S_AAD)) r_aad_left <= r_aad_left - CW'(1);
                if (w_load_blk && (r_state == S_TEXT)) begin
                    r_txt_left  <= r_txt_left - CW'(1);
                    r_ctr       <= r_ctr + 32'd1;
                    r_txt_first <= 1'b0;
                end
            end
        end
    end

    // Single-entry output register; it may drain and refill on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_blk     <= '0;
            r_ctr_blk <= '0;
            r_phase   <= '0;
            r_new     <= 1'b0;
            r_bytes   <= '0;
        end else if (w_load_blk || w_load_len) begin
            r_valid   <= 1'b1;
            r_blk     <= w_ld_blk;
            r_ctr_blk <= w_ld_ctr;
            r_phase   <= w_ld_phase;
            r_new     <= r_new_pending;
            r_bytes   <= w_ld_bytes;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_desc_ready   = (r_state == S_IDLE);
    assign o_blk_ready    = w_blk_ready;
    assign o_valid        = r_valid;
    assign o_blk          = r_blk;
    assign o_ctr_block    = r_ctr_blk;
    assign o_phase        = r_phase;
    assign o_new_instance = r_new;
    assign o_byte_cnt     = r_bytes;
    assign o_done         = w_len_acc;
endmodule

// File: tb/tb_gcm_block_sequencer.sv
// Randomized bench for gcm_block_sequencer against a block-list reference model; second instance covers counter wrap.
`timescale 1ns/1ps
module tb_gcm_block_sequencer;
    localparam int EW = 265;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_desc_valid, o_desc_ready;
    logic [95:0]  i_iv;
    logic [63:0]  i_aad_len, i_pt_len;
    logic         i_blk_valid, o_blk_ready;
    logic [127:0] i_blk;
    logic         o_valid, i_ready;
    logic [127:0] o_blk, o_ctr_block;
    logic [2:0]   o_phase;
    logic         o_new_instance;
    logic [4:0]   o_byte_cnt;
    logic         o_done, o_err;

    logic         wr_desc_valid, wr_desc_ready;
    logic [95:0]  wr_iv;
    logic [63:0]  wr_aad_len, wr_pt_len;
    logic         wr_blk_valid, wr_blk_ready;
    logic [127:0] wr_blk_in;
    logic         wr_valid, wr_ready;
    logic [127:0] wr_blk, wr_ctr_block;
    logic [2:0]   wr_phase;
    logic         wr_new, wr_done, wr_err;
    logic [4:0]   wr_byte_cnt;

    always #5 clk = ~clk;

    gcm_block_sequencer dut (
        .clk(clk), .rst(rst),
        .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
        .i_iv(i_iv), .i_aad_len(i_aad_len), .i_pt_len(i_pt_len),
        .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready), .i_blk(i_blk),
        .o_valid(o_valid), .i_ready(i_ready), .o_blk(o_blk), .o_ctr_block(o_ctr_block),
        .o_phase(o_phase), .o_new_instance(o_new_instance), .o_byte_cnt(o_byte_cnt),
        .o_done(o_done), .o_err(o_err)
    );

    gcm_block_sequencer #(.CTR_START(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst),
        .i_desc_valid(wr_desc_valid), .o_desc_ready(wr_desc_ready),
        .i_iv(wr_iv), .i_aad_len(wr_aad_len), .i_pt_len(wr_pt_len),
        .i_blk_valid(wr_blk_valid), .o_blk_ready(wr_blk_ready), .i_blk(wr_blk_in),
        .o_valid(wr_valid), .i_ready(wr_ready), .o_blk(wr_blk), .o_ctr_block(wr_ctr_block),
        .o_phase(wr_phase), .o_new_instance(wr_new), .o_byte_cnt(wr_byte_cnt),
        .o_done(wr_done), .o_err(wr_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entry layout: {blk[127:0], ctr_block[127:0], phase[2:0], new_instance, byte_cnt[4:0]}
    logic [127:0]  src_q[$];
    logic [EW-1:0] exp_q[$];

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [4:0] last_bytes(input longint unsigned len);
        return 5'((((len - 1) / 8) % 16) + 1);
    endfunction

    task automatic build_model(input logic [95:0] iv, input logic [63:0] aad, input logic [63:0] pt,
                               input logic [31:0] ctr0);
        longint unsigned na, nt;
        logic [127:0] b;
        logic [4:0]   nb;
        logic [2:0]   ph;
        logic         first;
        int           k;
        na = (aad + 127) / 128;
        nt = (pt + 127) / 128;
        k  = 0;
        src_q.delete();
        exp_q.delete();
        for (longint unsigned i = 0; i < na; i++) begin
            b = rand128();
            src_q.push_back(b);
            nb = (i == na - 1) ? last_bytes(aad) : 5'd16;
            first = (k == 0);
            exp_q.push_back({b, 128'd0, 3'b010, first, nb});
            k++;
        end
        for (longint unsigned i = 0; i < nt; i++) begin
            b = rand128();
            src_q.push_back(b);
            nb = (i == nt - 1) ? last_bytes(pt) : 5'd16;
            if (nt == 1)           ph = 3'b111;
            else if (i == 0)       ph = 3'b000;
            else if (i == nt - 1)  ph = 3'b011;
            else                   ph = 3'b001;
            first = (k == 0);
            exp_q.push_back({b, iv, ctr0 + 32'(i), ph, first, nb});
            k++;
        end
        first = (k == 0);
        exp_q.push_back({aad, pt, 128'd0, 3'b101, first, 5'd16});
    endtask

    task automatic send_desc(input logic [95:0] iv, input logic [63:0] aad, input logic [63:0] pt);
        int guard = 0;
        bit acc = 0;
        i_desc_valid = 1'b1;
        i_iv = iv;
        i_aad_len = aad;
        i_pt_len = pt;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = o_desc_ready;
            @(posedge clk); #1;
            guard++;
        end
        i_desc_valid = 1'b0;
        check("desc_accept", acc, 1);
    endtask

    task automatic drive_src();
        int idx = 0;
        int guard = 0;
        bit fired;
        while (idx < src_q.size() && guard < 4000) begin
            i_blk_valid = ($urandom_range(0, 3) != 0);
            i_blk = src_q[idx];
            @(negedge clk);
            fired = i_blk_valid && o_blk_ready;
            @(posedge clk); #1;
            if (fired) idx++;
            guard++;
        end
        i_blk_valid = 1'b0;
    endtask

    task automatic run_sink(input bit rnd_ready, input int stall_after);
        int guard = 0;
        int accepted = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit done = 0;
        bit held = 0;
        logic [EW-1:0] held_v, got, exp;
        while (!done && guard < 4000) begin
            if (stall_left > 0) begin
                i_ready = 1'b0;
                stall_left--;
            end else if (!stalled && stall_after >= 0 && accepted == stall_after) begin
                stalled = 1;
                stall_left = 4;
                i_ready = 1'b0;
            end else begin
                i_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            got = {o_blk, o_ctr_block, o_phase, o_new_instance, o_byte_cnt};
            check("desc_ready_busy", o_desc_ready, 0);
            if (held) check("stall_hold", {o_valid, got}, {1'b1, held_v});
            held = 0;
            if (o_valid && !i_ready) begin
                check("stall_blk_ready", o_blk_ready, 0);
                held = 1;
                held_v = got;
            end
            if (o_valid && i_ready) begin
                check("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("entry", got, exp);
                    check("done_pulse", o_done, exp[8:6] == 3'b101);
                    if (exp[8:6] == 3'b101) done = 1;
                end
                accepted++;
            end else begin
                check("done_quiet", o_done, 0);
            end
            @(posedge clk); #1;
            guard++;
        end
        check("sink_finished", done, 1);
        i_ready = 1'b0;
        @(negedge clk);
        check("desc_ready_after", o_desc_ready, 1);
        check("done_one_cycle", o_done, 0);
        check("q_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input logic [63:0] aad, input logic [63:0] pt, input bit rnd_ready,
                           input int stall_after);
        logic [95:0] iv;
        iv = {$urandom, $urandom, $urandom};
        build_model(iv, aad, pt, 32'd2);
        send_desc(iv, aad, pt);
        fork
            drive_src();
            run_sink(rnd_ready, stall_after);
        join
    endtask

    task automatic wrap_test();
        logic [31:0] ctrs[$];
        int guard = 0;
        bit fin = 0;
        wr_iv = {$urandom, $urandom, $urandom};
        wr_aad_len = 64'd0;
        wr_pt_len = 64'd256;
        wr_ready = 1'b1;
        wr_blk_valid = 1'b1;
        wr_blk_in = rand128();
        wr_desc_valid = 1'b1;
        while (!fin && guard < 50) begin
            @(negedge clk);
            if (wr_valid && wr_phase != 3'b101) ctrs.push_back(wr_ctr_block[31:0]);
            if (wr_valid && wr_phase == 3'b101) fin = 1;
            @(posedge clk); #1;
            if (!wr_desc_ready) wr_desc_valid = 1'b0;
            guard++;
        end
        wr_blk_valid = 1'b0;
        check("wrap_finished", fin, 1);
        check("wrap_count", ctrs.size(), 2);
        if (ctrs.size() == 2) begin
            check("wrap_ctr0", ctrs[0], 32'hFFFF_FFFF);
            check("wrap_ctr1", ctrs[1], 32'h0000_0000);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_desc_valid = 1'b0; i_iv = '0; i_aad_len = '0; i_pt_len = '0;
        i_blk_valid = 1'b0; i_blk = '0; i_ready = 1'b0;
        wr_desc_valid = 1'b0; wr_iv = '0; wr_aad_len = '0; wr_pt_len = '0;
        wr_blk_valid = 1'b0; wr_blk_in = '0; wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_desc_ready", o_desc_ready, 1);
        check("reset_outputs", {o_valid, o_blk_ready, o_blk, o_ctr_block, o_phase, o_new_instance,
                                o_byte_cnt, o_done, o_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(64'd256, 64'd384, 1'b0, -1);
        run_txn(64'd0, 64'd100, 1'b0, -1);
        run_txn(64'd0, 64'd0, 1'b0, -1);
        run_txn(64'd128, 64'd768, 1'b0, 3);
        run_txn(64'd77, 64'd1, 1'b1, 2);

        // Reset in the middle of a text stream, then confirm a clean restart.
        build_model({$urandom, $urandom, $urandom}, 64'd0, 64'd1024, 32'd2);
        send_desc(96'h1, 64'd0, 64'd1024);
        i_ready = 1'b1;
        i_blk_valid = 1'b1;
        i_blk = src_q[0];
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_desc_ready", o_desc_ready, 1);
        check("midrst_outputs", {o_valid, o_blk_ready, o_blk, o_ctr_block, o_phase, o_new_instance,
                                 o_byte_cnt, o_done, o_err}, 0);
        i_blk_valid = 1'b0;
        i_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(64'd0, 64'd300, 1'b1, -1);

        for (int t = 0; t < 25; t++) begin
            logic [63:0] a, p;
            a = ($urandom_range(0, 4) == 0) ? 64'd0 : 64'($urandom_range(1, 700));
            p = ($urandom_range(0, 4) == 0) ? 64'd0 : 64'($urandom_range(1, 900));
            run_txn(a, p, 1'b1, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4)));
        end

        wrap_test();

`ifdef GCM_CTR_WRAP_ERR_EN
        send_desc(96'h5, 64'd0, 64'h0000_007F_FFFF_FF80);
        @(negedge clk);
        check("err_pulse", o_err, 1);
        check("err_stays_idle", o_desc_ready, 1);
        check("err_no_output", o_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_one_cycle", o_err, 0);
        @(posedge clk); #1;
`else
        @(negedge clk);
        check("err_tied_low", o_err, 0);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
